// File: rtl/muldiv_seq.sv
// Shared sequential signed multiply/divide unit: radix-2 Booth multiply and
// restoring divide on one 65-bit accumulator, controlled by a start/fim handshake.
module muldiv_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        fim,
  output logic        busy,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_ITER,
    DIV_ITER,
    DIV_FIX,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_q, neg_d;
  logic        a_neg_q, a_neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        fim_q, fim_d;
  logic        busy_q, busy_d;
  logic        dz_q, dz_d;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] booth_sum;
  logic [32:0] div_sh;

  // Booth partial sum is kept 33 bits wide so subtracting the most negative
  // multiplicand cannot corrupt the sign carried into the arithmetic shift.
  always_comb begin
    a_mag     = a[31] ? -a : a;
    b_mag     = b[31] ? -b : b;
    booth_sum = {acc_q[64], acc_q[64:33]};
    case (acc_q[1:0])
      2'b01:   booth_sum = {acc_q[64], acc_q[64:33]} + {opnd_q[31], opnd_q};
      2'b10:   booth_sum = {acc_q[64], acc_q[64:33]} - {opnd_q[31], opnd_q};
      default: booth_sum = {acc_q[64], acc_q[64:33]};
    endcase
    div_sh = {acc_q[63:32], acc_q[31]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    a_neg_d = a_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    fim_d   = 1'b0;
    busy_d  = busy_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          dz_d    = 1'b0;
          busy_d  = 1'b1;
          neg_d   = a[31] ^ b[31];
          a_neg_d = a[31];
          if (!op) begin
            opnd_d  = a;
            acc_d   = {32'd0, b, 1'b0};
            state_d = MUL_ITER;
          end else begin
            opnd_d = b_mag;
            acc_d  = {33'd0, a_mag};
            // Divide-by-zero passes through DIV_FIX so its fim lands one edge after accept.
            if (b == '0) begin
              dz_d    = 1'b1;
              state_d = DIV_FIX;
            end else begin
              state_d = DIV_ITER;
            end
          end
        end
      end
      MUL_ITER: begin
        if (cnt_q == 6'd32) begin
          hi_d    = acc_q[64:33];
          lo_d    = acc_q[32:1];
          fim_d   = 1'b1;
          state_d = DONE;
        end else begin
          acc_d = {booth_sum, acc_q[32:1]};
          cnt_d = cnt_q + 6'd1;
        end
      end
      DIV_ITER: begin
        if (cnt_q == 6'd32) begin
          state_d = DIV_FIX;
        end else begin
          if (div_sh >= {1'b0, opnd_q}) begin
            acc_d = {div_sh - {1'b0, opnd_q}, acc_q[30:0], 1'b1};
          end else begin
            acc_d = {div_sh, acc_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end
      end
      DIV_FIX: begin
        if (!dz_q) begin
          lo_d = neg_q   ? -acc_q[31:0]  : acc_q[31:0];
          hi_d = a_neg_q ? -acc_q[63:32] : acc_q[63:32];
        end
        fim_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      fim_q   <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      a_neg_q <= a_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      fim_q   <= fim_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign fim      = fim_q;
  assign busy     = busy_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: products, quotients, latency,
// divide-by-zero, start protocol and asynchronous reset.
module tb_muldiv_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        fim;
  logic        busy;
  logic        div_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  muldiv_seq dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .fim      (fim),
    .busy     (busy),
    .div_zero (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, need summary");
    $fatal(1);
  end

  // Issues one op from IDLE, waits (bounded) for fim, captures the result and
  // returns one cycle later so the unit is back in IDLE.
  task automatic do_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                       output logic rdz, output logic busy_first, output logic busy_after);
    @(negedge clock);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    @(posedge clock);
    #1;
    start = 1'b0;
    a     = ~a_i;
    b     = ~b_i ^ 32'h5A5A_0F0F;
    busy_first = busy;
    lat = -1;
    rhi = 'x;
    rlo = 'x;
    rdz = 1'bx;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clock);
      #1;
      if (fim) begin
        lat = n;
        rhi = hi;
        rlo = lo;
        rdz = div_zero;
      end
    end
    @(posedge clock);
    #1;
    busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clock);
    #1;
    total_cnt++;
    if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo: got %h, need 0", {hi, lo});
    else pass_cnt++;
    total_cnt++;
    if ({fim, busy, div_zero} !== 3'b000)
      $display("FAIL reset_flags: got fim/busy/dz=%b, need 000", {fim, busy, div_zero});
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_mult();
    int lat;
    logic [31:0] rhi, rlo;
    logic rdz, bf, ba;
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, rhi, rlo, rdz, bf, ba);
    total_cnt++;
    if (lat !== 33) $display("FAIL mult_latency: got %0d, need 33", lat);
    else pass_cnt++;
    total_cnt++;
    if ({rhi, rlo} !== 64'hFFFF_FFFF_FFFF_FFEB)
      $display("FAIL mult_7x-3: got %h, need FFFFFFFFFFFFFFEB", {rhi, rlo});
    else pass_cnt++;
    total_cnt++;
    if (bf !== 1'b1) $display("FAIL mult_busy_start: got %b, need 1", bf);
    else pass_cnt++;
    total_cnt++;
    if (ba !== 1'b0) $display("FAIL mult_busy_end: got %b, need 0", ba);
    else pass_cnt++;

    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, rhi, rlo, rdz, bf, ba);
    total_cnt++;
    if ({rhi, rlo} !== 64'h4000_0000_0000_0000)
      $display("FAIL mult_minxmin: got %h, need 4000000000000000", {rhi, rlo});
    else pass_cnt++;

    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, lat, rhi, rlo, rdz, bf, ba);
    total_cnt++;
    if ({rhi, rlo} !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL mult_-1x1: got %h, need FFFFFFFFFFFFFFFF", {rhi, rlo});
    else pass_cnt++;
  endtask

  task automatic test_div();
    int lat;
    logic [31:0] rhi, rlo;
    logic rdz, bf, ba;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, rhi, rlo, rdz, bf, ba);
    total_cnt++;
    if (lat !== 34) $display("FAIL div_latency: got %0d, need 34", lat);
    else pass_cnt++;
    total_cnt++;
    if ({rhi, rlo} !== 64'hFFFF_FFFF_FFFF_FFFD)
      $display("FAIL div_-7/2: got hi/lo %h, need FFFFFFFFFFFFFFFD", {rhi, rlo});
    else pass_cnt++;
    total_cnt++;
    if (rdz !== 1'b0) $display("FAIL div_dz_clear: got %b, need 0", rdz);
    else pass_cnt++;

    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, rhi, rlo, rdz, bf, ba);
    total_cnt++;
    if ({rhi, rlo} !== 64'h0000_0001_FFFF_FFFD)
      $display("FAIL div_7/-2: got hi/lo %h, need 00000001FFFFFFFD", {rhi, rlo});
    else pass_cnt++;

    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, rhi, rlo, rdz, bf, ba);
    total_cnt++;
    if ({rhi, rlo} !== 64'h0000_0000_8000_0000)
      $display("FAIL div_min/-1: got hi/lo %h, need 0000000080000000", {rhi, rlo});
    else pass_cnt++;
    total_cnt++;
    if (rdz !== 1'b0) $display("FAIL div_min/-1_flag: got %b, need 0", rdz);
    else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int lat;
    logic [31:0] rhi, rlo;
    logic rdz, bf, ba;
    // 0x66 * 0x2AAAAAAB = 0x11_00000022
    do_op(1'b0, 32'h66, 32'h2AAA_AAAB, lat, rhi, rlo, rdz, bf, ba);
    total_cnt++;
    if ({rhi, rlo} !== 64'h0000_0011_0000_0022)
      $display("FAIL dz_setup_mult: got %h, need 0000001100000022", {rhi, rlo});
    else pass_cnt++;

    do_op(1'b1, 32'd5, 32'd0, lat, rhi, rlo, rdz, bf, ba);
    total_cnt++;
    if (lat !== 1) $display("FAIL dz_latency: got %0d, need 1", lat);
    else pass_cnt++;
    total_cnt++;
    if (rdz !== 1'b1) $display("FAIL dz_flag: got %b, need 1", rdz);
    else pass_cnt++;
    total_cnt++;
    if ({rhi, rlo} !== 64'h0000_0011_0000_0022)
      $display("FAIL dz_hold_hilo: got %h, need 0000001100000022", {rhi, rlo});
    else pass_cnt++;
    total_cnt++;
    if (ba !== 1'b0) $display("FAIL dz_busy_end: got %b, need 0", ba);
    else pass_cnt++;

    @(negedge clock);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd2;
    b     = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    total_cnt++;
    if (div_zero !== 1'b0) $display("FAIL dz_clear_on_accept: got %b, need 0", div_zero);
    else pass_cnt++;
    repeat (40) @(posedge clock);
    #1;
    total_cnt++;
    if ({hi, lo} !== 64'd6) $display("FAIL dz_next_mult: got %h, need 6", {hi, lo});
    else pass_cnt++;
  endtask

  task automatic test_start_held();
    logic [31:0] ah [0:79];
    logic [31:0] bh [0:79];
    int fims   = 0;
    int first  = -1;
    int second = -1;
    int idx;
    logic [63:0] expp;
    for (int e = 0; e < 80; e++) begin
      @(negedge clock);
      start = 1'b1;
      op    = 1'b0;
      a     = 32'(e * 3 + 1);
      b     = 32'(e + 5);
      ah[e] = a;
      bh[e] = b;
      @(posedge clock);
      #1;
      if (fim) begin
        fims++;
        if (first < 0) first = e;
        else if (second < 0) second = e;
        idx = (e >= 33) ? e - 33 : 0;
        expp = 64'(ah[idx]) * 64'(bh[idx]);
        total_cnt++;
        if (e < 33 || {hi, lo} !== expp)
          $display("FAIL held_result@%0d: got %h, need %h", e, {hi, lo}, expp);
        else pass_cnt++;
      end
    end
    start = 1'b0;
    total_cnt++;
    if (fims !== 2) $display("FAIL held_op_count: got %0d, need 2", fims);
    else pass_cnt++;
    total_cnt++;
    if (second - first !== 35) $display("FAIL held_spacing: got %0d, need 35", second - first);
    else pass_cnt++;
    repeat (45) @(posedge clock);
    #1;
  endtask

  task automatic test_start_in_done();
    int lat;
    logic [31:0] rhi, rlo;
    logic rdz, bf, ba;
    int extra = 0;
    @(negedge clock);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd9;
    b     = 32'd9;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clock);
      #1;
      if (fim) lat = n;
    end
    total_cnt++;
    if (lat !== 33) $display("FAIL done_setup_latency: got %0d, need 33", lat);
    else pass_cnt++;
    @(negedge clock);
    start = 1'b1;
    a     = 32'd100;
    b     = 32'd100;
    @(posedge clock);
    #1;
    start = 1'b0;
    total_cnt++;
    if ({busy, fim} !== 2'b00) $display("FAIL done_start_busy: got busy/fim %b, need 00", {busy, fim});
    else pass_cnt++;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (fim || busy) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL done_start_ignored: got %0d active cycles, need 0", extra);
    else pass_cnt++;
    total_cnt++;
    if ({hi, lo} !== 64'd81) $display("FAIL done_result: got %h, need 81", {hi, lo});
    else pass_cnt++;
    do_op(1'b0, 32'd1, 32'd1, lat, rhi, rlo, rdz, bf, ba);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rhi, rlo;
    logic rdz, bf, ba;
    int fims = 0;
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rhi, rlo, rdz, bf, ba);
    @(negedge clock);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({hi, lo} !== 64'd0) $display("FAIL rstmid_hilo: got %h, need 0", {hi, lo});
    else pass_cnt++;
    total_cnt++;
    if ({fim, busy, div_zero} !== 3'b000)
      $display("FAIL rstmid_flags: got fim/busy/dz=%b, need 000", {fim, busy, div_zero});
    else pass_cnt++;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clock);
      #1;
      if (fim) fims++;
    end
    total_cnt++;
    if (fims !== 0) $display("FAIL rstmid_no_fim: got %0d, need 0", fims);
    else pass_cnt++;
    do_op(1'b0, 32'd3, 32'd4, lat, rhi, rlo, rdz, bf, ba);
    total_cnt++;
    if ({rhi, rlo} !== 64'd12) $display("FAIL rstmid_mult3x4: got %h, need 12", {rhi, rlo});
    else pass_cnt++;
    total_cnt++;
    if (lat !== 33) $display("FAIL rstmid_latency: got %0d, need 33", lat);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_start_held();
    test_start_in_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
